rob_prn_reclaim: RTL and testbench
==================================

Name: rob_prn_reclaim

Overview:
- In-order retirement buffer on the free side of the register renamer.
- At dispatch it records, per instruction, the previous PRNs overwritten by that instruction's destinations.
- It tracks out-of-order completion and retires at most one instruction per cycle in program order.
- On retirement it returns the retired PRNs to the renamer free list, using the renamer's free_valid/free_prns interface.

Parameters:
- DEPTH, 16, number of entries; must be a power of two, at least 2.
- PRN_BITS, 6, physical register number width.
- MAX_OPERANDS, 3, maximum destination PRNs recorded per instruction; also the number of completion ports.
- IDX_BITS, $clog2(DEPTH), entry index width; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- alloc_valid  in  1  dispatch request for one instruction.
- alloc_old_valid  in  1 x MAX_OPERANDS  slot holds a PRN to free at retirement.
- alloc_old_prn  in  PRN_BITS x MAX_OPERANDS  PRNs to free at retirement.
- alloc_ready  out  1  buffer can accept an allocation this cycle.
- alloc_idx  out  IDX_BITS  index assigned to the current allocation (tail).
- complete_valid  in  1 x MAX_OPERANDS  completion strobes.
- complete_idx  in  IDX_BITS x MAX_OPERANDS  indices being marked done.
- free_valid  out  1 x MAX_OPERANDS  PRN release strobes to the renamer.
- free_prns  out  PRN_BITS x MAX_OPERANDS  PRNs released.
- commit_valid  out  1  an instruction retires this cycle.
- commit_idx  out  IDX_BITS  index retiring (head).
- count  out  IDX_BITS+1  occupied entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- Storage: per entry a valid bit, a done bit, and MAX_OPERANDS pairs of (old_valid, old_prn).
- Pointers: head and tail are IDX_BITS+1 wide, with a wrap bit.
  - count = tail - head, modulo 2^(IDX_BITS+1).
  - full when the index bits are equal and the wrap bits differ.
- Reset:
  - head = tail = 0; all valid and done bits = 0.
  - Outputs after reset: alloc_ready=1, alloc_idx=0, commit_valid=0, commit_idx=0, all free_valid=0, free_prns=0, count=0, empty=1, full=0.
- Allocation:
  - alloc_ready = !full, computed from registered state only. A commit in the same cycle does not make room until the next cycle.
  - When alloc_valid && alloc_ready, at the clock edge the entry at the tail index is written with valid=1, done=0 and the old PRN fields, and tail increments.
  - alloc_valid while !alloc_ready is ignored; no state changes.
- Completion:
  - For each i with complete_valid[i] and entry[complete_idx[i]].valid, done is set at the edge.
  - Completion to an invalid entry is ignored.
  - Duplicate indices across ports are harmless.
- Commit (combinational from registered state):
  - commit_valid = entry[head].valid && entry[head].done.
  - commit_idx = head index bits.
  - free_valid[i] = commit_valid && entry[head].old_valid[i].
  - free_prns[i] = entry[head].old_prn[i] when free_valid[i] is 1, else 0.
  - At the edge, when commit_valid: entry[head].valid=0, done=0, head increments.
- Latency:
  - A completion strobe at cycle N gives commit_valid and free_valid at cycle N+1 at the earliest, provided that entry is the head.
  - A completion strobe never bypasses the registered done bit.
- Simultaneous events:
  - Allocation and commit in the same cycle are both performed; count is unchanged.
  - Completion of the head entry in the same cycle as a commit of that entry cannot occur, because the entry is already done.
  - An allocation writing index k while index k retires is impossible, because the buffer is not full.
- Wrap-around: index bits wrap modulo DEPTH; the wrap bit toggles, so count and full stay correct across many laps.
- Reset mid-operation: all in-flight entries are discarded and none of their PRNs are freed. The renamer resets in the same cycle.

Optional Feature:
- Macro: ROB_PERF_EN.
- Defined: adds two outputs and their counters.
  - perf_commits (32 bits): counts cycles with commit_valid.
  - perf_full_stalls (32 bits): counts cycles with alloc_valid && full.
  - Both counters reset to 0, wrap at 2^32, and have no other effect on behaviour.
- Undefined: neither the ports nor the counters exist, and behaviour is otherwise identical.

Test Plan:
- Basic free: after reset, allocate with old_valid={1,0,1} and old_prn={5,x,9}, then complete_idx[0]=0 one cycle later. Required: the cycle after the completion gives commit_valid=1, commit_idx=0, free_valid={1,0,1}, free_prns={5,0,9}; the next cycle gives empty=1.
- In-order retire: allocate idx 0, 1, 2; complete 2, then 1, then 0 on separate cycles. Required: no commit until 0 is done, then commits of 0, 1, 2 on three consecutive cycles.
- Full: allocate 16 entries. Required: full=1, alloc_ready=0, and a 17th alloc_valid is ignored (count stays 16). Completing idx 0 gives one commit; alloc_ready=1 the following cycle, and the next allocation gets alloc_idx=0.
- Wrap-around: run 40 allocate/complete/retire cycles at steady state. Required: commit_idx sequence 0..15,0..15,0..7; count never exceeds 16; the free_prns order matches the allocation order.
- Stray completion: complete_idx=5 on an empty buffer, then allocate idx 0..5. Required: entry 5 is not done and does not commit without a new completion.
- Reset mid-flight: with 3 entries done but not yet committed, assert rst. Required: no free_valid the cycle after; count=0, empty=1, alloc_idx=0.

Source files
------------

// File: rtl/rob_prn_reclaim_if.sv
`default_nettype none
// ============================================================================
// Module      : rob_prn_reclaim_if
// Description : Dispatch, completion, retirement and status bundle between the
//               dispatch/execute side (master) and the PRN reclaim ROB (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface rob_prn_reclaim_if #(
  parameter int DEPTH        = 16,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3
);
  localparam int IDX_BITS = $clog2(DEPTH);

  logic                                   alloc_valid;
  logic [MAX_OPERANDS-1:0]                alloc_old_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  alloc_old_prn;
  logic                                   alloc_ready;
  logic [IDX_BITS-1:0]                    alloc_idx;

  logic [MAX_OPERANDS-1:0]                complete_valid;
  logic [MAX_OPERANDS-1:0][IDX_BITS-1:0]  complete_idx;

  logic [MAX_OPERANDS-1:0]                free_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  free_prns;
  logic                                   commit_valid;
  logic [IDX_BITS-1:0]                    commit_idx;

  logic [IDX_BITS:0]                      count;
  logic                                   empty;
  logic                                   full;

  // Dispatch/execute side
  modport master (
    output alloc_valid, alloc_old_valid, alloc_old_prn,
    output complete_valid, complete_idx,
    input  alloc_ready, alloc_idx,
    input  free_valid, free_prns, commit_valid, commit_idx,
    input  count, empty, full
  );

  // Reclaim buffer side
  modport slave (
    input  alloc_valid, alloc_old_valid, alloc_old_prn,
    input  complete_valid, complete_idx,
    output alloc_ready, alloc_idx,
    output free_valid, free_prns, commit_valid, commit_idx,
    output count, empty, full
  );
endinterface
`default_nettype wire

// File: rtl/rob_prn_reclaim.sv
`default_nettype none
// ============================================================================
// Module      : rob_prn_reclaim
// Description : In-order retirement buffer holding the previous PRNs of each
//               dispatched instruction; marks out-of-order completions and
//               returns the old PRNs to the renamer free list at retirement,
//               at most one instruction per cycle.
//               Optional ROB_PERF_EN adds perf_commits / perf_full_stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_prn_reclaim #(
  parameter int DEPTH        = 16,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3
) (
  input  logic                clk,
  input  logic                rst,
  rob_prn_reclaim_if.slave    bus
`ifdef ROB_PERF_EN
  ,
  output logic [31:0]         perf_commits,
  output logic [31:0]         perf_full_stalls
`endif
);
  localparam int IDX_BITS = $clog2(DEPTH);

  // Entry storage and pointers (pointers carry an extra wrap bit)
  logic [DEPTH-1:0]                                   valid_q, valid_d;
  logic [DEPTH-1:0]                                   done_q, done_d;
  logic [DEPTH-1:0][MAX_OPERANDS-1:0]                 old_valid_q, old_valid_d;
  logic [DEPTH-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]   old_prn_q, old_prn_d;
  logic [IDX_BITS:0]                                  head_q, head_d;
  logic [IDX_BITS:0]                                  tail_q, tail_d;

  logic [IDX_BITS-1:0] w_head_idx;
  logic [IDX_BITS-1:0] w_tail_idx;
  logic                w_full;
  logic                w_commit;
  logic                w_alloc_fire;

  assign w_head_idx   = head_q[IDX_BITS-1:0];
  assign w_tail_idx   = tail_q[IDX_BITS-1:0];
  assign w_full       = (w_head_idx == w_tail_idx) && (head_q[IDX_BITS] != tail_q[IDX_BITS]);
  assign w_commit     = valid_q[w_head_idx] && done_q[w_head_idx];
  // Readiness looks only at registered state; a same-cycle commit frees room next cycle.
  assign w_alloc_fire = bus.alloc_valid && !w_full;

  assign bus.alloc_ready  = !w_full;
  assign bus.alloc_idx    = w_tail_idx;
  assign bus.commit_valid = w_commit;
  assign bus.commit_idx   = w_head_idx;
  assign bus.count        = tail_q - head_q;
  assign bus.empty        = (tail_q == head_q);
  assign bus.full         = w_full;

  // Per-slot release strobes; PRN forced to zero when the slot is not released
  for (genvar gi = 0; gi < MAX_OPERANDS; gi++) begin : g_free
    assign bus.free_valid[gi] = w_commit && old_valid_q[w_head_idx][gi];
    assign bus.free_prns[gi]  = bus.free_valid[gi] ? old_prn_q[w_head_idx][gi] : '0;
  end

  // Next-state: completion marks, then retirement at head, then allocation at tail
  always_comb begin
    valid_d     = valid_q;
    done_d      = done_q;
    old_valid_d = old_valid_q;
    old_prn_d   = old_prn_q;
    head_d      = head_q;
    tail_d      = tail_q;

    // Completions only land on live entries; duplicates simply set the bit twice.
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      if (bus.complete_valid[i] && valid_q[bus.complete_idx[i]]) begin
        done_d[bus.complete_idx[i]] = 1'b1;
      end
    end

    if (w_commit) begin
      valid_d[w_head_idx] = 1'b0;
      done_d[w_head_idx]  = 1'b0;
      head_d              = head_q + 1'b1;
    end

    // The tail entry is never live when not full, so this cannot collide with
    // the retirement or completion updates above.
    if (w_alloc_fire) begin
      valid_d[w_tail_idx]     = 1'b1;
      done_d[w_tail_idx]      = 1'b0;
      old_valid_d[w_tail_idx] = bus.alloc_old_valid;
      old_prn_d[w_tail_idx]   = bus.alloc_old_prn;
      tail_d                  = tail_q + 1'b1;
    end
  end

  // State registers; reset drops all in-flight entries without freeing them
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      done_q      <= '0;
      old_valid_q <= '0;
      old_prn_q   <= '0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      valid_q     <= valid_d;
      done_q      <= done_d;
      old_valid_q <= old_valid_d;
      old_prn_q   <= old_prn_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

`ifdef ROB_PERF_EN
  logic [31:0] perf_commits_q, perf_commits_d;
  logic [31:0] perf_full_stalls_q, perf_full_stalls_d;

  // Free-running event counters, wrapping at 2^32
  always_comb begin
    perf_commits_d     = perf_commits_q + {31'd0, w_commit};
    perf_full_stalls_d = perf_full_stalls_q + {31'd0, (bus.alloc_valid && w_full)};
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_commits_q     <= '0;
      perf_full_stalls_q <= '0;
    end else begin
      perf_commits_q     <= perf_commits_d;
      perf_full_stalls_q <= perf_full_stalls_d;
    end
  end

  assign perf_commits     = perf_commits_q;
  assign perf_full_stalls = perf_full_stalls_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rob_prn_reclaim.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob_prn_reclaim
// Description : Directed self-checking bench for rob_prn_reclaim.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_prn_reclaim;
  localparam int DEPTH        = 16;
  localparam int PRN_BITS     = 6;
  localparam int MAX_OPERANDS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rob_prn_reclaim_if #(.DEPTH(DEPTH), .PRN_BITS(PRN_BITS), .MAX_OPERANDS(MAX_OPERANDS)) bus ();

`ifdef ROB_PERF_EN
  logic [31:0] perf_commits;
  logic [31:0] perf_full_stalls;
`endif

  rob_prn_reclaim #(.DEPTH(DEPTH), .PRN_BITS(PRN_BITS), .MAX_OPERANDS(MAX_OPERANDS)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus)
`ifdef ROB_PERF_EN
    ,
    .perf_commits     (perf_commits),
    .perf_full_stalls (perf_full_stalls)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_valid     = 1'b0;
    bus.alloc_old_valid = '0;
    bus.alloc_old_prn   = '0;
    bus.complete_valid  = '0;
    bus.complete_idx    = '0;
  endtask

  task automatic set_alloc(input logic [2:0] ov, input logic [5:0] p0, input logic [5:0] p1,
                           input logic [5:0] p2);
    bus.alloc_valid      = 1'b1;
    bus.alloc_old_valid  = ov;
    bus.alloc_old_prn[0] = p0;
    bus.alloc_old_prn[1] = p1;
    bus.alloc_old_prn[2] = p2;
  endtask

  task automatic set_comp(input logic [2:0] cv, input logic [3:0] i0, input logic [3:0] i1,
                          input logic [3:0] i2);
    bus.complete_valid  = cv;
    bus.complete_idx[0] = i0;
    bus.complete_idx[1] = i1;
    bus.complete_idx[2] = i2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  // Wrap-test scoreboard
  int prn_q[$];
  int exp_idx;
  int n_com;
  int max_cnt;
  int exp_prn;

  initial begin
    // ---------------- Reset state ----------------
    do_reset();
    check_eq("rst_alloc_ready", bus.alloc_ready, 1);
    check_eq("rst_alloc_idx", bus.alloc_idx, 0);
    check_eq("rst_commit_valid", bus.commit_valid, 0);
    check_eq("rst_commit_idx", bus.commit_idx, 0);
    check_eq("rst_free_valid", bus.free_valid, 0);
    check_eq("rst_free_prns", bus.free_prns, 0);
    check_eq("rst_count", bus.count, 0);
    check_eq("rst_empty", bus.empty, 1);
    check_eq("rst_full", bus.full, 0);

    // ---------------- Basic free ----------------
    set_alloc(3'b101, 6'd5, 6'd33, 6'd9);
    step();
    idle_inputs();
    set_comp(3'b001, 4'd0, 4'd0, 4'd0);
    check_eq("basic_no_bypass", bus.commit_valid, 0);
    step();
    idle_inputs();
    check_eq("basic_commit_valid", bus.commit_valid, 1);
    check_eq("basic_commit_idx", bus.commit_idx, 0);
    check_eq("basic_free_valid", bus.free_valid, 3'b101);
    check_eq("basic_free_prn0", bus.free_prns[0], 5);
    check_eq("basic_free_prn1", bus.free_prns[1], 0);
    check_eq("basic_free_prn2", bus.free_prns[2], 9);
    step();
    check_eq("basic_empty", bus.empty, 1);
    check_eq("basic_count", bus.count, 0);
    check_eq("basic_free_after", bus.free_valid, 0);

    // ---------------- In-order retire ----------------
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_alloc(3'b001, 6'(10 + i), 6'd0, 6'd0);
      step();
    end
    idle_inputs();
    set_comp(3'b001, 4'd2, 4'd0, 4'd0);
    step();
    check_eq("ino_wait_after_c2", bus.commit_valid, 0);
    set_comp(3'b001, 4'd1, 4'd0, 4'd0);
    step();
    check_eq("ino_wait_after_c1", bus.commit_valid, 0);
    set_comp(3'b001, 4'd0, 4'd0, 4'd0);
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      check_eq("ino_commit_valid", bus.commit_valid, 1);
      check_eq("ino_commit_idx", bus.commit_idx, i);
      check_eq("ino_free_prn", bus.free_prns[0], 10 + i);
      step();
    end
    check_eq("ino_empty", bus.empty, 1);

    // ---------------- Full ----------------
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      check_eq("full_fill_idx", bus.alloc_idx, i);
      set_alloc(3'b001, 6'(20 + i), 6'd0, 6'd0);
      step();
    end
    check_eq("full_full", bus.full, 1);
    check_eq("full_ready", bus.alloc_ready, 0);
    check_eq("full_count", bus.count, 16);
    set_alloc(3'b001, 6'd63, 6'd0, 6'd0);
    step();
    idle_inputs();
    check_eq("full_ignored_count", bus.count, 16);
    set_comp(3'b001, 4'd0, 4'd0, 4'd0);
    step();
    idle_inputs();
    check_eq("full_commit_valid", bus.commit_valid, 1);
    check_eq("full_commit_prn", bus.free_prns[0], 20);
    check_eq("full_ready_same_cycle", bus.alloc_ready, 0);
    step();
    check_eq("full_commit_once", bus.commit_valid, 0);
    check_eq("full_ready_next", bus.alloc_ready, 1);
    check_eq("full_count_15", bus.count, 15);
    check_eq("full_next_idx", bus.alloc_idx, 0);
    set_alloc(3'b001, 6'd40, 6'd0, 6'd0);
    step();
    idle_inputs();
    check_eq("full_refill_count", bus.count, 16);

    // ---------------- Wrap-around ----------------
    do_reset();
    exp_idx = 0;
    n_com   = 0;
    max_cnt = 0;
    prn_q.delete();
    for (int c = 0; c < 44; c++) begin
      idle_inputs();
      if (c < 40) begin
        check_eq("wrap_alloc_idx", bus.alloc_idx, c % 16);
        set_alloc(3'b001, 6'((c * 7 + 3) % 64), 6'd0, 6'd0);
        prn_q.push_back((c * 7 + 3) % 64);
      end
      if (c >= 1 && c <= 40) begin
        set_comp(3'b001, 4'((c - 1) % 16), 4'd0, 4'd0);
      end
      if (bus.commit_valid) begin
        check_eq("wrap_commit_idx", bus.commit_idx, exp_idx);
        exp_prn = (prn_q.size() > 0) ? prn_q.pop_front() : -1;
        check_eq("wrap_free_prn", bus.free_prns[0], exp_prn);
        exp_idx = (exp_idx + 1) % 16;
        n_com++;
      end
      if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
      step();
    end
    idle_inputs();
    check_eq("wrap_commit_total", n_com, 40);
    check_eq("wrap_count_over_depth", (max_cnt > 16), 0);
    check_eq("wrap_final_empty", bus.empty, 1);

    // ---------------- Stray completion ----------------
    do_reset();
    set_comp(3'b001, 4'd5, 4'd0, 4'd0);
    step();
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      set_alloc(3'b001, 6'(50 + i), 6'd0, 6'd0);
      step();
    end
    idle_inputs();
    n_com = 0;
    for (int j = 0; j < 10; j++) begin
      idle_inputs();
      if (j == 0) set_comp(3'b111, 4'd0, 4'd1, 4'd2);
      if (j == 1) set_comp(3'b011, 4'd3, 4'd4, 4'd0);
      step();
      if (bus.commit_valid) n_com++;
    end
    idle_inputs();
    check_eq("stray_commits", n_com, 5);
    check_eq("stray_head5_not_done", bus.commit_valid, 0);
    check_eq("stray_head_idx", bus.commit_idx, 5);
    check_eq("stray_count", bus.count, 1);
    set_comp(3'b001, 4'd5, 4'd0, 4'd0);
    step();
    idle_inputs();
    check_eq("stray_commit5", bus.commit_valid, 1);
    check_eq("stray_commit5_prn", bus.free_prns[0], 55);

    // ---------------- Reset mid-flight ----------------
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_alloc(3'b001, 6'(30 + i), 6'd0, 6'd0);
      step();
    end
    idle_inputs();
    set_comp(3'b111, 4'd1, 4'd2, 4'd3);
    step();
    idle_inputs();
    check_eq("midrst_pre_count", bus.count, 4);
    check_eq("midrst_pre_no_commit", bus.commit_valid, 0);
    rst = 1'b1;
    step();
    check_eq("midrst_free_valid", bus.free_valid, 0);
    check_eq("midrst_count", bus.count, 0);
    check_eq("midrst_empty", bus.empty, 1);
    check_eq("midrst_alloc_idx", bus.alloc_idx, 0);
    rst = 1'b0;
    step();
    check_eq("midrst_after_commit", bus.commit_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
